pipe_stage_skid_reg: RTL

Parametrised pipeline-stage register with a two-entry skid buffer, valid/ready handshakes on both sides, an external freeze (hazard stall) and a synchronous flush that injects a programmable bubble value. It replaces the fixed 32+32-bit IF/ID register: instantiated with DATA_W = 64 carrying {PC, Instruction}, it sits between fetch and decode. It is also reused between later stages that need backpressure without a combinational ready path.

---
 rtl/pipe_stage_skid_reg.sv | 85 ++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline register with two-entry skid buffer, freeze, flush bubble and stall counter
module pipe_stage_skid_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx, skid_q, skid_nx;
    logic              in_fire, out_fire, stall;
    assign in_ready  = (state != TWO) & !freeze & !flush;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & !freeze;
    assign stall     = out_valid & !out_ready & !freeze & !flush;
    // state and payload registers; main holds the bubble value whenever empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= FLUSH_VAL;
            skid_q <= '0;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end
    // next state: flush beats freeze, freeze holds everything, otherwise fill/drain in order
    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = FLUSH_VAL;
            skid_nx  = '0;
        end else if (!freeze) begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = ONE;
                    main_nx  = in_data;
                end
                ONE: if (in_fire && out_fire) begin
                    main_nx = in_data;
                end else if (in_fire) begin
                    state_nx = TWO;
                    skid_nx  = in_data;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                    main_nx  = FLUSH_VAL;
                end
                TWO: if (out_fire) begin
                    state_nx = ONE;
                    main_nx  = skid_q;
                    skid_nx  = '0;
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = FLUSH_VAL;
                    skid_nx  = '0;
                end
            endcase
        end
    end
    // saturating count of cycles where valid output waits on downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule
